// File: rtl/extern_return_router_head_if.sv
// Handshake bundle between the extern return router head and its neighbours:
// call-id capture, in-order extern return, and the switch-chain injection port.
interface extern_return_router_head_if #(
   parameter int NUM_OUTPUT_PORTS = 3,
   parameter int DATA_WIDTH       = 16
);
   localparam int ID_W = (NUM_OUTPUT_PORTS > 1) ? $clog2(NUM_OUTPUT_PORTS) : 1;
   localparam int MC_W = $clog2(NUM_OUTPUT_PORTS) + 1;

   logic                  call_valid;
   logic                  call_ready;
   logic [ID_W-1:0]       call_port_id;
   logic                  ret_valid;
   logic                  ret_ready;
   logic [DATA_WIDTH-1:0] ret_data;
   logic                  out_valid;
   logic                  out_ready;
   logic [MC_W-1:0]       out_match_counter;
   logic [DATA_WIDTH-1:0] out_data;

   modport master (
      output call_valid, call_port_id, ret_valid, ret_data, out_ready,
      input  call_ready, ret_ready, out_valid, out_match_counter, out_data
   );

   modport slave (
      input  call_valid, call_port_id, ret_valid, ret_data, out_ready,
      output call_ready, ret_ready, out_valid, out_match_counter, out_data
   );
endinterface

// File: rtl/extern_return_router_head.sv
// Injection head of the extern return router chain: queues caller ids in issue order and
// tags each in-order return with a match_counter. Optional checks: EXTERN_RETURN_ROUTER_HEAD_CHECK_EN.
module extern_return_router_head #(
   parameter int NUM_OUTPUT_PORTS = 3,
   parameter int DATA_WIDTH       = 16,
   parameter int MAX_OUTSTANDING  = 4
) (
   input  logic clk,
   input  logic rst,
   extern_return_router_head_if.slave bus,
   output logic [$clog2(MAX_OUTSTANDING+1)-1:0] outstanding_count
`ifdef EXTERN_RETURN_ROUTER_HEAD_CHECK_EN
   ,
   output logic err_bad_port
`endif
);
   localparam int ID_W  = (NUM_OUTPUT_PORTS > 1) ? $clog2(NUM_OUTPUT_PORTS) : 1;
   localparam int MC_W  = $clog2(NUM_OUTPUT_PORTS) + 1;
   localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);
   localparam int PTR_W = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;

   // Pointers wrap at the FIFO depth, which need not be a power of two.
   function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] ptr);
      logic [PTR_W-1:0] nxt;
      if (ptr == PTR_W'(MAX_OUTSTANDING - 1)) begin
         nxt = {PTR_W{1'b0}};
      end else begin
         nxt = ptr + PTR_W'(1'b1);
      end
      return nxt;
   endfunction

   // Id 0 becomes all ones so node 0 sees MSB=1; id k needs k decrements to get there.
   function automatic logic [MC_W-1:0] encode_mc(input logic [ID_W-1:0] id);
      logic [MC_W-1:0] ext;
      ext = MC_W'(id);
      return ext - MC_W'(1'b1);
   endfunction

   logic [ID_W-1:0]       id_mem_r [MAX_OUTSTANDING];
   logic [PTR_W-1:0]      wr_ptr_r;
   logic [PTR_W-1:0]      rd_ptr_r;
   logic [CNT_W-1:0]      count_r;
   logic [CNT_W-1:0]      count_nxt_s;
   logic                  out_valid_r;
   logic [MC_W-1:0]       out_mc_r;
   logic [DATA_WIDTH-1:0] out_data_r;
   logic                  call_ready_s;
   logic                  ret_ready_s;
   logic                  push_s;
   logic                  pop_s;

   // Handshake qualification from registered state only; no push/pop bypass.
   always_comb begin
      call_ready_s = (count_r < CNT_W'(MAX_OUTSTANDING));
      ret_ready_s  = (count_r != {CNT_W{1'b0}}) && (!out_valid_r || bus.out_ready);
      push_s       = bus.call_valid && call_ready_s;
      pop_s        = bus.ret_valid && ret_ready_s;
      case ({push_s, pop_s})
         2'b10:   count_nxt_s = count_r + CNT_W'(1'b1);
         2'b01:   count_nxt_s = count_r - CNT_W'(1'b1);
         default: count_nxt_s = count_r;
      endcase
   end

   // FIFO pointers and occupancy; reset discards every held id.
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_r <= {PTR_W{1'b0}};
         rd_ptr_r <= {PTR_W{1'b0}};
         count_r  <= {CNT_W{1'b0}};
      end else begin
         if (push_s) begin
            wr_ptr_r <= next_ptr(wr_ptr_r);
         end
         if (pop_s) begin
            rd_ptr_r <= next_ptr(rd_ptr_r);
         end
         count_r <= count_nxt_s;
      end
   end

   // Id storage; contents are don't-care while the slot is not occupied.
   always_ff @(posedge clk) begin
      if (push_s) begin
         id_mem_r[wr_ptr_r] <= bus.call_port_id;
      end
   end

   // Single output stage: reloads on acceptance, empties on consumption, otherwise holds.
   always_ff @(posedge clk) begin
      if (rst) begin
         out_valid_r <= 1'b0;
         out_mc_r    <= {MC_W{1'b0}};
         out_data_r  <= {DATA_WIDTH{1'b0}};
      end else if (pop_s) begin
         out_valid_r <= 1'b1;
         out_mc_r    <= encode_mc(id_mem_r[rd_ptr_r]);
         out_data_r  <= bus.ret_data;
      end else if (bus.out_ready) begin
         out_valid_r <= 1'b0;
      end else begin
         out_valid_r <= out_valid_r;
      end
   end

   assign bus.call_ready        = call_ready_s;
   assign bus.ret_ready         = ret_ready_s;
   assign bus.out_valid         = out_valid_r;
   assign bus.out_match_counter = out_mc_r;
   assign bus.out_data          = out_data_r;
   assign outstanding_count     = count_r;

`ifdef EXTERN_RETURN_ROUTER_HEAD_CHECK_EN
   logic bad_port_s;
   logic err_bad_port_r;

   // An out-of-range id is still queued; it is only flagged here.
   always_comb begin
      bad_port_s = push_s &&
                   ({1'b0, bus.call_port_id} >= (ID_W+1)'(NUM_OUTPUT_PORTS));
   end

   // Sticky error flag, cleared only by reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         err_bad_port_r <= 1'b0;
      end else if (bad_port_s) begin
         err_bad_port_r <= 1'b1;
      end else begin
         err_bad_port_r <= err_bad_port_r;
      end
   end

   assign err_bad_port = err_bad_port_r;

   extern_return_router_head_chk #(
      .CNT_W (CNT_W)
   ) u_chk (
      .clk               (clk),
      .rst               (rst),
      .bad_call          (bad_port_s),
      .ret_valid         (bus.ret_valid),
      .outstanding_count (count_r)
   );
`endif
endmodule

`ifdef EXTERN_RETURN_ROUTER_HEAD_CHECK_EN
// Simulation checks for the router head: illegal caller ids and orphan returns.
module extern_return_router_head_chk #(
   parameter int CNT_W = 3
) (
   input logic             clk,
   input logic             rst,
   input logic             bad_call,
   input logic             ret_valid,
   input logic [CNT_W-1:0] outstanding_count
);
   logic [10:0] orphan_cnt_r;

   // Counts consecutive cycles of a return offered with nothing outstanding.
   always_ff @(posedge clk) begin
      if (rst) begin
         orphan_cnt_r <= 11'd0;
      end else if (ret_valid && (outstanding_count == {CNT_W{1'b0}})) begin
         if (orphan_cnt_r != 11'd1025) begin
            orphan_cnt_r <= orphan_cnt_r + 11'd1;
         end
         if (orphan_cnt_r == 11'd1024) begin
            $error("extern_return_router_head: orphan return held over 1024 cycles");
         end
      end else begin
         orphan_cnt_r <= 11'd0;
      end
   end

   // Reports each accepted call carrying an out-of-range port id.
   always_ff @(posedge clk) begin
      if (!rst && bad_call) begin
         $error("extern_return_router_head: call accepted with illegal port id");
      end
   end
endmodule
`endif

// File: tb/tb_extern_return_router_head.sv
// Randomised scoreboard bench for extern_return_router_head against a queue-based model.
module tb_extern_return_router_head;
   localparam int NPORTS = 3;
   localparam int DW     = 16;
   localparam int MAXO   = 4;

   logic       clk;
   logic       rst;
   logic [2:0] outstanding_count;
`ifdef EXTERN_RETURN_ROUTER_HEAD_CHECK_EN
   logic       err_bad_port;
   localparam int MAX_ID = 2;
`else
   localparam int MAX_ID = 3;
`endif

   extern_return_router_head_if #(.NUM_OUTPUT_PORTS(NPORTS), .DATA_WIDTH(DW)) bus ();

   extern_return_router_head #(
      .NUM_OUTPUT_PORTS (NPORTS),
      .DATA_WIDTH       (DW),
      .MAX_OUTSTANDING  (MAXO)
   ) dut (
      .clk               (clk),
      .rst               (rst),
      .bus               (bus),
      .outstanding_count (outstanding_count)
`ifdef EXTERN_RETURN_ROUTER_HEAD_CHECK_EN
      ,
      .err_bad_port      (err_bad_port)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_bad = 0;

   // Reference model: ids in issue order, expected words in delivery order.
   int unsigned id_q[$];
   logic [18:0] exp_q[$];
   bit          m_out_valid;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // One clock cycle: inputs are already driven; compare handshakes, advance model.
   task automatic step();
      bit          cr, rr, cf, rf;
      int unsigned pid;
      logic [2:0]  mc;
      #1;
      cr = (id_q.size() < MAXO);
      rr = (id_q.size() != 0) && (!m_out_valid || bus.out_ready);
      chk("call_ready", 32'(bus.call_ready), 32'(cr));
      chk("ret_ready", 32'(bus.ret_ready), 32'(rr));
      chk("outstanding_count", 32'(outstanding_count), 32'(id_q.size()));
      chk("out_valid", 32'(bus.out_valid), 32'(m_out_valid));
`ifdef EXTERN_RETURN_ROUTER_HEAD_CHECK_EN
      chk("err_bad_port", 32'(err_bad_port), 32'd0);
`endif
      cf = bus.call_valid && cr;
      rf = bus.ret_valid && rr;
      if (rf) begin
         pid = id_q.pop_front();
         mc  = 3'((pid + 32'd7) % 32'd8);
         exp_q.push_back({mc, bus.ret_data});
      end
      if (cf) id_q.push_back(32'(bus.call_port_id));
      if (rf) m_out_valid = 1'b1;
      else if (bus.out_ready) m_out_valid = 1'b0;
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic do_reset();
      rst            = 1'b1;
      bus.call_valid = 1'b0;
      bus.ret_valid  = 1'b0;
      @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      id_q.delete();
      exp_q.delete();
      m_out_valid = 1'b0;
   endtask

   task automatic drive(input bit cv, input int unsigned id, input bit rv,
                        input logic [15:0] d, input bit ordy);
      bus.call_valid   = cv;
      bus.call_port_id = 2'(id);
      bus.ret_valid    = rv;
      bus.ret_data     = d;
      bus.out_ready    = ordy;
   endtask

   // Monitor: checks the presented word against the scoreboard head, pops on consumption.
   always @(negedge clk) begin
      #2;
      if (!rst && bus.out_valid === 1'b1) begin
         if (exp_q.size() == 0) begin
            chk("spurious out_valid", 32'(bus.out_valid), 32'd0);
         end else begin
            chk("out_match_counter", 32'(bus.out_match_counter), 32'(exp_q[0][18:16]));
            chk("out_data", 32'(bus.out_data), 32'(exp_q[0][15:0]));
            if (bus.out_ready) void'(exp_q.pop_front());
         end
      end
   end

   initial begin
      rst = 1'b1;
      drive(1'b0, 0, 1'b0, 16'h0000, 1'b1);
      do_reset();
      do_reset();

      // Idle with an orphan return offered: nothing may be accepted.
      drive(1'b0, 0, 1'b1, 16'hDEAD, 1'b1);
      for (int i = 0; i < 10; i++) step();

      // Ids 0,1,2 then three returns.
      for (int i = 0; i < 3; i++) begin
         drive(1'b1, i, 1'b0, 16'h0000, 1'b1);
         step();
      end
      drive(1'b0, 0, 1'b1, 16'hAAAA, 1'b1); step();
      drive(1'b0, 0, 1'b1, 16'hBBBB, 1'b1); step();
      drive(1'b0, 0, 1'b1, 16'hCCCC, 1'b1); step();
      drive(1'b0, 0, 1'b0, 16'h0000, 1'b1);
      for (int i = 0; i < 3; i++) step();

`ifndef EXTERN_RETURN_ROUTER_HEAD_CHECK_EN
      // Out-of-range id is queued and encoded unchanged.
      drive(1'b1, 3, 1'b0, 16'h0000, 1'b1); step();
      drive(1'b0, 0, 1'b1, 16'h5555, 1'b1); step();
      drive(1'b0, 0, 1'b0, 16'h0000, 1'b1); step();
`endif

      // Fill to capacity, refused fifth call, then pop with a refused push.
      for (int i = 0; i < 5; i++) begin
         drive(1'b1, i % 3, 1'b0, 16'h0000, 1'b1);
         step();
      end
      drive(1'b1, 1, 1'b1, 16'h7777, 1'b1); step();
      for (int i = 0; i < 4; i++) begin
         drive(1'b0, 0, 1'b1, 16'(16'h0100 + i), 1'b1);
         step();
      end

      // Output stall with a second return pending, then back-to-back release.
      drive(1'b1, 2, 1'b0, 16'h0000, 1'b1); step();
      drive(1'b1, 0, 1'b0, 16'h0000, 1'b1); step();
      drive(1'b0, 0, 1'b1, 16'h1111, 1'b0); step();
      drive(1'b0, 0, 1'b1, 16'h2222, 1'b0);
      for (int i = 0; i < 5; i++) step();
      drive(1'b0, 0, 1'b1, 16'h2222, 1'b1); step();
      drive(1'b0, 0, 1'b0, 16'h0000, 1'b1); step();
      step();

      // Reset with three ids outstanding and a word held.
      for (int i = 0; i < 4; i++) begin
         drive(1'b1, i % 3, 1'b0, 16'h0000, 1'b0);
         step();
      end
      drive(1'b0, 0, 1'b1, 16'h9999, 1'b0); step();
      drive(1'b0, 0, 1'b0, 16'h0000, 1'b0);
      do_reset();
      drive(1'b0, 0, 1'b0, 16'h0000, 1'b1); step();
      drive(1'b1, 2, 1'b0, 16'h0000, 1'b1); step();
      drive(1'b0, 0, 1'b1, 16'h1234, 1'b1); step();
      drive(1'b0, 0, 1'b0, 16'h0000, 1'b1); step();

      // Randomised traffic with occasional resets.
      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(0, 299) == 0) begin
            do_reset();
         end else begin
            drive(1'($urandom_range(0, 1)), $urandom_range(0, MAX_ID),
                  1'($urandom_range(0, 1)), 16'($urandom()),
                  ($urandom_range(0, 9) < 7));
            step();
         end
      end

      // Drain and confirm every expected word was delivered.
      drive(1'b0, 0, 1'b0, 16'h0000, 1'b1);
      for (int i = 0; i < 4; i++) step();
      chk("scoreboard drained", 32'(exp_q.size()), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule

// File: doc/extern_return_router_head.md
Name: extern_return_router_head

Overview:
- Head (injection) stage of the extern return router chain; sits directly upstream of the first switch node.
- Records the caller port id of each extern call in issue order, in a small FIFO.
- Pairs each in-order extern return with the oldest recorded id, encodes the id as a match_counter and presents {match_counter, data} on the switch input handshake.
- Each switch node along the chain delivers on match_counter MSB=1, otherwise decrements and forwards.

Parameters:
- NUM_OUTPUT_PORTS, 3: number of switch nodes/callers in the chain (>=1).
- DATA_WIDTH, 16: return payload width.
- MAX_OUTSTANDING, 4: depth of the caller-id FIFO (>=1); bounds calls in flight.
- Derived: ID_W = max(1, $clog2(NUM_OUTPUT_PORTS)); MC_W = $clog2(NUM_OUTPUT_PORTS)+1; CNT_W = $clog2(MAX_OUTSTANDING+1).

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- call_valid  in  1  caller issued an extern call
- call_ready  out  1  call id can be recorded
- call_port_id  in  ID_W  index of calling port (0 = first switch node)
- ret_valid  in  1  extern return available (returns arrive in call order)
- ret_ready  out  1  return accepted
- ret_data  in  DATA_WIDTH  return payload
- out_valid  out  1  switch input valid
- out_ready  in  1  switch input ready
- out_match_counter  out  MC_W  routing counter for switch chain
- out_data  out  DATA_WIDTH  payload to switch chain
- outstanding_count  out  CNT_W  ids currently held in FIFO

Behaviour:
- Reset: id FIFO empty, outstanding_count=0, out_valid=0, out_match_counter=0, out_data=0, call_ready=1 (registered/derived from count), ret_ready=0. Reset mid-operation discards all held ids and any pending output word.
- Call handshake: a call is accepted when call_valid&call_ready. call_ready = (outstanding_count < MAX_OUTSTANDING). It uses the registered count only: a full FIFO does not accept a push even if a pop occurs the same cycle.
- Return handshake: a return is accepted when ret_valid&ret_ready. ret_ready = (outstanding_count != 0) & (!out_valid | out_ready). There is no bypass: an id pushed in cycle t can pair with a return no earlier than cycle t+1.
- Simultaneous push and pop (not full, not empty): both occur and the count is unchanged. The FIFO read/write pointers wrap modulo MAX_OUTSTANDING, with correct behaviour for non-power-of-two depth.
- Output register: single stage, latency 1. On return acceptance in cycle t, the following appear in cycle t+1 with out_valid=1:
  - out_data = ret_data
  - out_match_counter = (popped_id - 1) mod 2^MC_W, so id 0 yields all ones (MSB=1, delivered at node 0) and id k reaches node k after k decrements.
- out_valid holds, with stable data, until out_ready. When out_ready and a new acceptance occur together, the register reloads and there is no bubble (full throughput of 1 return/cycle).
- call_port_id >= NUM_OUTPUT_PORTS is illegal. It is stored and encoded unchanged, and the chain will not deliver it.
- outstanding_count = pushes minus pops. It never exceeds MAX_OUTSTANDING.

Optional Feature:
- Macro: EXTERN_RETURN_ROUTER_HEAD_CHECK_EN.
- Enabled:
  - Adds output port err_bad_port (1 bit, reset 0). It is sticky-set the cycle after a call is accepted with call_port_id >= NUM_OUTPUT_PORTS.
  - Adds a simulation-only $error on that event.
  - Adds a simulation-only $error when ret_valid is high for more than 1024 consecutive cycles while outstanding_count==0 (orphan return).
  - err_bad_port clears only on rst.
- Disabled: port and checks absent; datapath identical.

Test Plan (NUM_OUTPUT_PORTS=3, DATA_WIDTH=16, MAX_OUTSTANDING=4):
- Reset then idle -> out_valid=0, call_ready=1, ret_ready=0, outstanding_count=0 for 10 cycles, even with ret_valid=1 held.
- Calls with ids 0,1,2, then returns 0xAAAA, 0xBBBB, 0xCCCC with out_ready=1 -> outputs in order {3'b111,AAAA}, {3'b000,BBBB}, {3'b001,CCCC}, each 1 cycle after acceptance.
- Issue 4 calls without returns -> call_ready=0 on the fifth, count=4. A pop plus a push attempt in the same cycle -> push refused, count=3.
- out_ready=0 for 5 cycles with a word held and a second return pending -> out_valid held, data stable, ret_ready=0. Raising out_ready -> back-to-back delivery with no bubble.
- Assert rst with 3 ids outstanding and out_valid=1 -> next cycle out_valid=0 and count=0; a subsequent call with id 2 followed by return 0x1234 -> {3'b001,1234}.
- With CHECK_EN defined, call with id 3 -> err_bad_port=1 next cycle, remains set until rst, and the matching output has match_counter 3'b010.
